// File: rtl/window_generator_if.sv
`timescale 1ns/1ps
// window_generator_if
// Pixel-stream and window-output bundle of window_generator.
//   start          single-cycle pulse that arms a new frame
//   pixelIn        input pixel, raster order
//   pixelValid     pixelIn is valid this cycle
//   window         KSIZE*KSIZE pixels, element (r,c) at [(r*KSIZE+c)*PIXEL_W +: PIXEL_W]
//   windowValid    window/centerRow/centerCol are valid this cycle
//   centerRow/Col  image coordinates of the window centre
//   busy           frame in progress
//   imageProcessed single-cycle end-of-frame pulse
//
// Handshake: push-only, no backpressure. A pixel is taken on a rising edge
// where pixelValid=1 and the block is in a frame (FILL/STREAM); otherwise it
// is dropped. windowValid is likewise a one-cycle qualifier with no ready.
interface window_generator_if #(
  parameter int PIXEL_W = 8,
  parameter int KSIZE   = 3,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic                          start;
  logic [PIXEL_W-1:0]            pixelIn;
  logic                          pixelValid;
  logic [KSIZE*KSIZE*PIXEL_W-1:0] window;
  logic                          windowValid;
  logic [ROW_W-1:0]              centerRow;
  logic [COL_W-1:0]              centerCol;
  logic                          busy;
  logic                          imageProcessed;

  modport master (
    output start, pixelIn, pixelValid,
    input  window, windowValid, centerRow, centerCol, busy, imageProcessed
  );

  modport slave (
    input  start, pixelIn, pixelValid,
    output window, windowValid, centerRow, centerCol, busy, imageProcessed
  );
endinterface

// File: rtl/window_generator.sv
`timescale 1ns/1ps
// window_generator
// K x K neighbourhood window generator. Keeps the previous KSIZE-1 rows in
// line buffers and emits one window per accepted pixel once the window lies
// fully inside the image. Latency: pixel taken at edge N -> window after N+2.
// Ports:
//   mainClk      sole clock, rising edge
//   reset        asynchronous, active-high
//   bus          window_generator_if slave (stream in, windows out)
//   o_dbg_state  current FSM state (IDLE=0, FILL=1, STREAM=2, DRAIN=3)
module window_generator #(
  parameter int PIXEL_W = 8,
  parameter int KSIZE   = 3,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480
) (
  input  logic                mainClk,
  input  logic                reset,
  window_generator_if.slave   bus,
  output logic [1:0]          o_dbg_state
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int HALF  = (KSIZE - 1) / 2;
  localparam int WIN_W = KSIZE * KSIZE * PIXEL_W;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_WIN0 = COL_W'(KSIZE - 1);
  localparam logic [ROW_W-1:0] ROW_WIN0 = ROW_W'(KSIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DRAIN} state_t;
  state_t r_state, w_next;

  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [PIXEL_W-1:0] r_lb     [KSIZE-1][IMG_W];
  logic [PIXEL_W-1:0] r_s1_col [KSIZE];
  logic [PIXEL_W-1:0] r_sh     [KSIZE][KSIZE];
  logic               r_s1_vld, r_s1_emit, r_s2_emit;
  logic [ROW_W-1:0]   r_s1_crow, r_s2_crow, r_crow;
  logic [COL_W-1:0]   r_s1_ccol, r_s2_ccol, r_ccol;
  logic [WIN_W-1:0]   r_window, w_sh_flat;
  logic               r_win_valid, r_done;
  logic               w_accept, w_emit, w_last_px;

  assign w_accept  = bus.pixelValid && (r_state == S_FILL || r_state == S_STREAM);
  assign w_emit    = (r_row >= ROW_WIN0) && (r_col >= COL_WIN0);
  assign w_last_px = (r_row == ROW_LAST) && (r_col == COL_LAST);

  // FSM state register
  always_ff @(posedge mainClk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state. A start in the imageProcessed cycle is ignored (r_done).
  // DRAIN ends once both pipeline stages are empty and the final window is
  // on the outputs, so imageProcessed lands one cycle after it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start && !r_done)             w_next = S_FILL;
      S_FILL:   if (w_accept && r_row == ROW_WIN0)    w_next = S_STREAM;
      S_STREAM: if (w_accept && w_last_px)            w_next = S_DRAIN;
      S_DRAIN:  if (!r_s1_vld && !r_s2_emit && r_win_valid) w_next = S_IDLE;
      default:                                        w_next = S_IDLE;
    endcase
  end

  // Line buffers (read-before-write cascade) and window shift register.
  // Pure data: never observable until refilled by the current frame, so no reset.
  always_ff @(posedge mainClk) begin
    if (w_accept) begin
      r_s1_col[KSIZE-1] <= bus.pixelIn;
      for (int i = 0; i < KSIZE - 1; i++) r_s1_col[KSIZE-2-i] <= r_lb[i][r_col];
      r_lb[0][r_col] <= bus.pixelIn;
      for (int i = 0; i < KSIZE - 2; i++) r_lb[i+1][r_col] <= r_lb[i][r_col];
    end
    if (r_s1_vld) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 1; c++) r_sh[r][c] <= r_sh[r][c+1];
        r_sh[r][KSIZE-1] <= r_s1_col[r];
      end
    end
  end

  always_comb begin
    w_sh_flat = '0;
    for (int r = 0; r < KSIZE; r++)
      for (int c = 0; c < KSIZE; c++)
        w_sh_flat[(r*KSIZE+c)*PIXEL_W +: PIXEL_W] = r_sh[r][c];
  end

  // Counters, pipeline qualifiers and output registers
  always_ff @(posedge mainClk or posedge reset) begin
    if (reset) begin
      r_row       <= '0;
      r_col       <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_emit   <= 1'b0;
      r_s1_crow   <= '0;
      r_s1_ccol   <= '0;
      r_s2_emit   <= 1'b0;
      r_s2_crow   <= '0;
      r_s2_ccol   <= '0;
      r_window    <= '0;
      r_win_valid <= 1'b0;
      r_crow      <= '0;
      r_ccol      <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == S_DRAIN) && (w_next == S_IDLE);

      if (r_state == S_IDLE && w_next == S_FILL) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_accept) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      // stage 1: line-buffer read captured alongside the incoming pixel
      r_s1_vld  <= w_accept;
      r_s1_emit <= w_accept && w_emit;
      if (w_accept) begin
        r_s1_crow <= r_row - ROW_W'(HALF);
        r_s1_ccol <= r_col - COL_W'(HALF);
      end

      // stage 2: shift register updated (in the data block above)
      r_s2_emit <= r_s1_vld && r_s1_emit;
      if (r_s1_vld) begin
        r_s2_crow <= r_s1_crow;
        r_s2_ccol <= r_s1_ccol;
      end

      // output stage: holds its value between windows
      r_win_valid <= r_s2_emit;
      if (r_s2_emit) begin
        r_window <= w_sh_flat;
        r_crow   <= r_s2_crow;
        r_ccol   <= r_s2_ccol;
      end
    end
  end

  assign bus.window         = r_window;
  assign bus.windowValid    = r_win_valid;
  assign bus.centerRow      = r_crow;
  assign bus.centerCol      = r_ccol;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.imageProcessed = r_done;
  assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_window_generator.sv
`timescale 1ns/1ps
module tb_window_generator;
  localparam int PW  = 8;
  localparam int K3  = 3, W3 = 8, H3 = 6, NW3 = (W3 - K3 + 1) * (H3 - K3 + 1);
  localparam int K5  = 5, W5 = 8, H5 = 8, NW5 = (W5 - K5 + 1) * (H5 - K5 + 1);
  localparam int WB3 = K3 * K3 * PW;
  localparam int WB5 = K5 * K5 * PW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  window_generator_if #(.PIXEL_W(PW), .KSIZE(K3), .IMG_W(W3), .IMG_H(H3)) if3 ();
  window_generator_if #(.PIXEL_W(PW), .KSIZE(K5), .IMG_W(W5), .IMG_H(H5)) if5 ();
  logic [1:0] st3, st5;

  window_generator #(.PIXEL_W(PW), .KSIZE(K3), .IMG_W(W3), .IMG_H(H3)) dut3 (
    .mainClk(clk), .reset(rst), .bus(if3), .o_dbg_state(st3));
  window_generator #(.PIXEL_W(PW), .KSIZE(K5), .IMG_W(W5), .IMG_H(H5)) dut5 (
    .mainClk(clk), .reset(rst), .bus(if5), .o_dbg_state(st5));

  // ---------------- frame store, scoreboard, monitors ----------------
  logic [PW-1:0]  frm [8][8];
  logic [WB3-1:0] exp3_q[$];
  int             exp3_row[$], exp3_col[$];
  logic [WB5-1:0] exp5_q[$];
  int             exp5_row[$], exp5_col[$];

  logic [WB3-1:0] obs3_win[$];
  int             obs3_row[$], obs3_col[$], obs3_cyc[$];
  int             ip3_cnt = 0, ip3_cyc = 0;
  logic [WB5-1:0] obs5_win[$];
  int             obs5_row[$], obs5_col[$];
  int             ip5_cnt = 0;

  always @(negedge clk) begin
    if (if3.windowValid === 1'b1) begin
      obs3_win.push_back(if3.window);
      obs3_row.push_back(int'(if3.centerRow));
      obs3_col.push_back(int'(if3.centerCol));
      obs3_cyc.push_back(cyc);
    end
    if (if3.imageProcessed === 1'b1) begin
      ip3_cnt++;
      ip3_cyc = cyc;
    end
    if (if5.windowValid === 1'b1) begin
      obs5_win.push_back(if5.window);
      obs5_row.push_back(int'(if5.centerRow));
      obs5_col.push_back(int'(if5.centerCol));
    end
    if (if5.imageProcessed === 1'b1) ip5_cnt++;
  end

  task automatic clear_obs();
    obs3_win.delete(); obs3_row.delete(); obs3_col.delete(); obs3_cyc.delete();
    obs5_win.delete(); obs5_row.delete(); obs5_col.delete();
    ip3_cnt = 0; ip5_cnt = 0; ip3_cyc = 0;
  endtask

  // Reference model: every window centred fully inside the image, in raster
  // order of its centre, elements taken straight from the frame.
  task automatic fill_frame(input int nrows, input bit ramp);
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < 8; c++)
        frm[r][c] = ramp ? PW'(r * 16 + c) : PW'($urandom_range(255));
  endtask

  task automatic model3();
    logic [WB3-1:0] w;
    exp3_q.delete(); exp3_row.delete(); exp3_col.delete();
    for (int cr = K3 / 2; cr < H3 - K3 / 2; cr++)
      for (int cc = K3 / 2; cc < W3 - K3 / 2; cc++) begin
        w = '0;
        for (int r = 0; r < K3; r++)
          for (int c = 0; c < K3; c++)
            w[(r*K3+c)*PW +: PW] = frm[cr-K3/2+r][cc-K3/2+c];
        exp3_q.push_back(w); exp3_row.push_back(cr); exp3_col.push_back(cc);
      end
  endtask

  task automatic model5();
    logic [WB5-1:0] w;
    exp5_q.delete(); exp5_row.delete(); exp5_col.delete();
    for (int cr = K5 / 2; cr < H5 - K5 / 2; cr++)
      for (int cc = K5 / 2; cc < W5 - K5 / 2; cc++) begin
        w = '0;
        for (int r = 0; r < K5; r++)
          for (int c = 0; c < K5; c++)
            w[(r*K5+c)*PW +: PW] = frm[cr-K5/2+r][cc-K5/2+c];
        exp5_q.push_back(w); exp5_row.push_back(cr); exp5_col.push_back(cc);
      end
  endtask

  // ---------------- drivers ----------------
  task automatic set_inputs(input bit sel, input bit s, input bit v, input logic [PW-1:0] p);
    if (sel) begin
      if5.start = s; if5.pixelValid = v; if5.pixelIn = p;
    end else begin
      if3.start = s; if3.pixelValid = v; if3.pixelIn = p;
    end
  endtask

  task automatic pulse_start(input bit sel, input bit with_pixel);
    set_inputs(sel, 1'b1, with_pixel, PW'($urandom_range(255)));
    @(posedge clk); #1;
    set_inputs(sel, 1'b0, 1'b0, '0);
  endtask

  // Streams frm in raster order with a pixelValid duty of `duty` percent.
  // stop_idx aborts before that pixel; start is raised while pixel start_idx
  // is offered. acc22 is the cycle on which pixel (2,2) was taken.
  task automatic drive(input bit sel, input int duty, input int stop_idx,
                       input int start_idx, output int acc22);
    int nrows;
    bit v;
    nrows = sel ? H5 : H3;
    acc22 = -1;
    for (int idx = 0; idx < nrows * 8; idx++) begin
      if (idx == stop_idx) break;
      do begin
        v = (int'($urandom_range(99)) < duty);
        set_inputs(sel, idx == start_idx, v, v ? frm[idx/8][idx%8] : PW'($urandom_range(255)));
        @(posedge clk); #1;
        if (v && idx == 2 * 8 + 2) acc22 = cyc;
      end while (!v);
    end
    set_inputs(sel, 1'b0, 1'b0, '0);
  endtask

  task automatic wait_ip(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if ((sel ? ip5_cnt : ip3_cnt) != 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_inputs(0, 0, 0, '0);
    set_inputs(1, 0, 0, '0);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (if3.window !== '0) begin n_fail++; $display("FAIL rst_window: got %h expected 0", if3.window); end
    n_checks++; if (if3.windowValid !== 1'b0) begin n_fail++; $display("FAIL rst_windowValid: got %b expected 0", if3.windowValid); end
    n_checks++; if (if3.centerRow !== '0) begin n_fail++; $display("FAIL rst_centerRow: got %0d expected 0", if3.centerRow); end
    n_checks++; if (if3.centerCol !== '0) begin n_fail++; $display("FAIL rst_centerCol: got %0d expected 0", if3.centerCol); end
    n_checks++; if (if3.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", if3.busy); end
    n_checks++; if (if3.imageProcessed !== 1'b0) begin n_fail++; $display("FAIL rst_imageProcessed: got %b expected 0", if3.imageProcessed); end
    n_checks++; if (st3 !== 2'd0) begin n_fail++; $display("FAIL rst_state3: got %0d expected 0", st3); end
    n_checks++; if (if5.busy !== 1'b0 || if5.windowValid !== 1'b0) begin n_fail++; $display("FAIL rst_dut5: got busy=%b wv=%b expected 0/0", if5.busy, if5.windowValid); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_ramp_continuous();
    int acc; bit ok;
    logic [WB3-1:0] fw, lw;
    int fe[9], le[9];
    fe = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
    le = '{53, 54, 55, 69, 70, 71, 85, 86, 87};
    for (int i = 0; i < 9; i++) begin
      fw[i*PW +: PW] = PW'(fe[i]);
      lw[i*PW +: PW] = PW'(le[i]);
    end
    clear_obs(); fill_frame(H3, 1'b1); model3();
    pulse_start(0, 1'b0);
    n_checks++; if (if3.busy !== 1'b1) begin n_fail++; $display("FAIL ramp_busy_rise: got %b expected 1", if3.busy); end
    drive(0, 100, -1, -1, acc);
    wait_ip(0, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ramp_ip_timeout: got %b expected 1", ok); end
    n_checks++; if (obs3_win.size() != NW3) begin n_fail++; $display("FAIL ramp_count: got %0d expected %0d", obs3_win.size(), NW3); end
    for (int i = 0; i < obs3_win.size() && i < exp3_q.size(); i++) begin
      n_checks++;
      if (obs3_win[i] !== exp3_q[i] || obs3_row[i] != exp3_row[i] || obs3_col[i] != exp3_col[i]) begin
        n_fail++;
        $display("FAIL ramp_win[%0d]: got c=(%0d,%0d) w=%h expected c=(%0d,%0d) w=%h",
                 i, obs3_row[i], obs3_col[i], obs3_win[i], exp3_row[i], exp3_col[i], exp3_q[i]);
      end
    end
    if (obs3_win.size() > 0) begin
      n_checks++; if (obs3_win[0] !== fw || obs3_row[0] != 1 || obs3_col[0] != 1) begin n_fail++; $display("FAIL ramp_first: got c=(%0d,%0d) w=%h expected c=(1,1) w=%h", obs3_row[0], obs3_col[0], obs3_win[0], fw); end
      n_checks++; if (obs3_cyc[0] != acc + 2) begin n_fail++; $display("FAIL ramp_latency: got cycle %0d expected %0d", obs3_cyc[0], acc + 2); end
      n_checks++; if (obs3_win[$] !== lw || obs3_row[$] != 4 || obs3_col[$] != 6) begin n_fail++; $display("FAIL ramp_last: got c=(%0d,%0d) w=%h expected c=(4,6) w=%h", obs3_row[$], obs3_col[$], obs3_win[$], lw); end
      n_checks++; if (ip3_cyc != obs3_cyc[$] + 1) begin n_fail++; $display("FAIL ramp_ip_timing: got cycle %0d expected %0d", ip3_cyc, obs3_cyc[$] + 1); end
    end
    n_checks++; if (ip3_cnt != 1) begin n_fail++; $display("FAIL ramp_ip_count: got %0d expected 1", ip3_cnt); end
    n_checks++; if (if3.busy !== 1'b0) begin n_fail++; $display("FAIL ramp_busy_fall: got %b expected 0", if3.busy); end
  endtask

  task automatic test_gaps();
    int acc; bit ok;
    clear_obs(); fill_frame(H3, 1'b1); model3();
    pulse_start(0, 1'b0);
    drive(0, 40, -1, -1, acc);
    wait_ip(0, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL gaps_ip_timeout: got %b expected 1", ok); end
    n_checks++; if (obs3_win.size() != NW3) begin n_fail++; $display("FAIL gaps_count: got %0d expected %0d", obs3_win.size(), NW3); end
    for (int i = 0; i < obs3_win.size() && i < exp3_q.size(); i++) begin
      n_checks++;
      if (obs3_win[i] !== exp3_q[i] || obs3_row[i] != exp3_row[i] || obs3_col[i] != exp3_col[i]) begin
        n_fail++;
        $display("FAIL gaps_win[%0d]: got c=(%0d,%0d) w=%h expected c=(%0d,%0d) w=%h",
                 i, obs3_row[i], obs3_col[i], obs3_win[i], exp3_row[i], exp3_col[i], exp3_q[i]);
      end
    end
    n_checks++; if (ip3_cnt != 1) begin n_fail++; $display("FAIL gaps_ip_count: got %0d expected 1", ip3_cnt); end
  endtask

  task automatic test_start_rules();
    int acc; bit ok;
    clear_obs(); fill_frame(H3, 1'b0); model3();
    for (int i = 0; i < 5; i++) begin
      set_inputs(0, 1'b0, 1'b1, PW'($urandom_range(255)));
      @(posedge clk); #1;
    end
    set_inputs(0, 1'b0, 1'b0, '0);
    n_checks++; if (st3 !== 2'd0 || if3.busy !== 1'b0) begin n_fail++; $display("FAIL idle_pixels: got state=%0d busy=%b expected 0/0", st3, if3.busy); end
    pulse_start(0, 1'b1);
    drive(0, 100, -1, 20, acc);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (if3.imageProcessed === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rules_ip_timeout: got %b expected 1", ok); end
    if (ok) begin
      set_inputs(0, 1'b1, 1'b0, '0);
      @(posedge clk); #1;
      set_inputs(0, 1'b0, 1'b0, '0);
      n_checks++; if (if3.busy !== 1'b0) begin n_fail++; $display("FAIL start_in_ip_cycle: got busy=%b expected 0", if3.busy); end
      set_inputs(0, 1'b1, 1'b0, '0);
      @(posedge clk); #1;
      set_inputs(0, 1'b0, 1'b0, '0);
      n_checks++; if (if3.busy !== 1'b1) begin n_fail++; $display("FAIL start_after_ip: got busy=%b expected 1", if3.busy); end
    end
    n_checks++; if (obs3_win.size() != NW3) begin n_fail++; $display("FAIL rules_count: got %0d expected %0d", obs3_win.size(), NW3); end
    for (int i = 0; i < obs3_win.size() && i < exp3_q.size(); i++) begin
      n_checks++;
      if (obs3_win[i] !== exp3_q[i] || obs3_row[i] != exp3_row[i] || obs3_col[i] != exp3_col[i]) begin
        n_fail++;
        $display("FAIL rules_win[%0d]: got c=(%0d,%0d) w=%h expected c=(%0d,%0d) w=%h",
                 i, obs3_row[i], obs3_col[i], obs3_win[i], exp3_row[i], exp3_col[i], exp3_q[i]);
      end
    end
    // the frame armed just after imageProcessed
    clear_obs(); fill_frame(H3, 1'b0); model3();
    drive(0, 60, -1, -1, acc);
    wait_ip(0, ok);
    n_checks++; if (obs3_win.size() != NW3) begin n_fail++; $display("FAIL rearm_count: got %0d expected %0d", obs3_win.size(), NW3); end
    for (int i = 0; i < obs3_win.size() && i < exp3_q.size(); i++) begin
      n_checks++;
      if (obs3_win[i] !== exp3_q[i] || obs3_row[i] != exp3_row[i] || obs3_col[i] != exp3_col[i]) begin
        n_fail++;
        $display("FAIL rearm_win[%0d]: got c=(%0d,%0d) w=%h expected c=(%0d,%0d) w=%h",
                 i, obs3_row[i], obs3_col[i], obs3_win[i], exp3_row[i], exp3_col[i], exp3_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int acc; bit ok;
    clear_obs(); fill_frame(H3, 1'b0);
    pulse_start(0, 1'b0);
    drive(0, 100, 3 * 8 + 4, -1, acc);
    #1 rst = 1'b1;
    #1;
    n_checks++; if (if3.window !== '0 || if3.windowValid !== 1'b0) begin n_fail++; $display("FAIL midrst_window: got wv=%b w=%h expected 0/0", if3.windowValid, if3.window); end
    n_checks++; if (if3.centerRow !== '0 || if3.centerCol !== '0) begin n_fail++; $display("FAIL midrst_centre: got (%0d,%0d) expected (0,0)", if3.centerRow, if3.centerCol); end
    n_checks++; if (if3.busy !== 1'b0 || st3 !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got busy=%b state=%0d expected 0/0", if3.busy, st3); end
    @(negedge clk) rst = 1'b0;
    clear_obs(); fill_frame(H3, 1'b0); model3();
    pulse_start(0, 1'b0);
    drive(0, 100, -1, -1, acc);
    wait_ip(0, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_ip_timeout: got %b expected 1", ok); end
    n_checks++; if (obs3_win.size() != NW3) begin n_fail++; $display("FAIL midrst_count: got %0d expected %0d", obs3_win.size(), NW3); end
    for (int i = 0; i < obs3_win.size() && i < exp3_q.size(); i++) begin
      n_checks++;
      if (obs3_win[i] !== exp3_q[i] || obs3_row[i] != exp3_row[i] || obs3_col[i] != exp3_col[i]) begin
        n_fail++;
        $display("FAIL midrst_win[%0d]: got c=(%0d,%0d) w=%h expected c=(%0d,%0d) w=%h",
                 i, obs3_row[i], obs3_col[i], obs3_win[i], exp3_row[i], exp3_col[i], exp3_q[i]);
      end
    end
  endtask

  task automatic test_ksize5();
    int acc; bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      clear_obs(); fill_frame(H5, pass == 0); model5();
      pulse_start(1, 1'b0);
      drive(1, (pass == 0) ? 100 : 40, -1, -1, acc);
      wait_ip(1, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL k5_ip_timeout[%0d]: got %b expected 1", pass, ok); end
      n_checks++; if (obs5_win.size() != NW5) begin n_fail++; $display("FAIL k5_count[%0d]: got %0d expected %0d", pass, obs5_win.size(), NW5); end
      for (int i = 0; i < obs5_win.size() && i < exp5_q.size(); i++) begin
        n_checks++;
        if (obs5_win[i] !== exp5_q[i] || obs5_row[i] != exp5_row[i] || obs5_col[i] != exp5_col[i]) begin
          n_fail++;
          $display("FAIL k5_win[%0d][%0d]: got c=(%0d,%0d) w=%h expected c=(%0d,%0d) w=%h",
                   pass, i, obs5_row[i], obs5_col[i], obs5_win[i], exp5_row[i], exp5_col[i], exp5_q[i]);
        end
      end
      if (obs5_win.size() > 0) begin
        n_checks++; if (obs5_row[0] != 2 || obs5_col[0] != 2) begin n_fail++; $display("FAIL k5_first_centre: got (%0d,%0d) expected (2,2)", obs5_row[0], obs5_col[0]); end
        n_checks++; if (obs5_row[$] != 5 || obs5_col[$] != 5) begin n_fail++; $display("FAIL k5_last_centre: got (%0d,%0d) expected (5,5)", obs5_row[$], obs5_col[$]); end
      end
      n_checks++; if (ip5_cnt != 1) begin n_fail++; $display("FAIL k5_ip_count[%0d]: got %0d expected 1", pass, ip5_cnt); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ramp_continuous();
    test_gaps();
    test_start_rules();
    test_reset_mid_frame();
    test_ksize5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
